mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 133 +++++++++++++
 tb/tb_mem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-wide instruction/data memory responder: valid/ready request, programmable
// wait states, byte-masked store or load, response held until accepted.
module mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic             bad_addr;
  logic             mem_we;

  assign idx      = addr_q[IDX_W+1:2];
  assign bad_addr = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));

  // Gated by reset so a store caught in ACCESS by reset never lands.
  assign mem_we = reset && (state_q == ACCESS) && write_q && !bad_addr;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          err_d   = 1'b0;
          if (LATENCY == 0) begin
            state_d = ACCESS;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        err_d        = bad_addr;
        if (bad_addr || write_q) rdata_d = 32'd0;
        else                     rdata_d = mem[idx];
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table on a LATENCY=2 instance plus
// hand sequences for backpressure, reset mid-flight and a LATENCY=0 instance.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        req_valid_b = 1'b0, req_write_b = 1'b0;
  logic [31:0] req_addr_b = '0, req_wdata_b = '0;
  logic [3:0]  req_be_b = '0;
  logic        req_ready_b, resp_valid_b, resp_err_b, busy_b;
  logic [31:0] resp_rdata_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  mem_responder #(.DEPTH(16), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_be(req_be_b),
    .resp_valid(resp_valid_b), .resp_ready(1'b1),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b), .busy(busy_b)
  );

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Present one request on the LATENCY=2 instance; returns once resp_valid is seen.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output logic er,
                         output int lat, output logic err_at_acc);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    err_at_acc = resp_err;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er, ea;
    int          lat;
    int          bad;
    int          acc_e[$];
    int          rise_e[$];
    logic        rdy, prev_rv;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'h0, 1'b1};
    vecs[6]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0010, 32'hAAAA_AAAA, 4'h0, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_b_idle", {30'd0, req_ready_b, busy_b}, 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;

    // Vector table, resp_ready held high
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("v%0d_req_ready", i), {31'd0, req_ready}, 32'd1);
      run_txn(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat, ea);
      chk($sformatf("v%0d_err_cleared_on_accept", i), {31'd0, ea}, 32'd0);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT + 1));
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      @(posedge clk); #1;
      chk($sformatf("v%0d_back_to_idle", i), {30'd0, resp_valid, req_ready}, 32'd1);
    end

    // Backpressure: hold resp_ready low for 5 cycles in RESP
    resp_ready = 1'b0;
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ea);
    chk("bp_latency", 32'(lat), 32'(LAT + 1));
    chk("bp_rdata", rd, 32'hDE22_BE44);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
        req_wdata = 32'h0BAD_0BAD; req_be = 4'hF;
      end
      if (c == 2) req_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", c), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_rdata", c), resp_rdata, 32'hDE22_BE44);
      chk($sformatf("bp_hold%0d_err_ready", c), {30'd0, resp_err, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {30'd0, resp_valid, req_ready}, 32'd1);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (resp_valid || busy) bad++;
    end
    chk("bp_no_extra_response", 32'(bad), 32'd0);
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ea);
    chk("bp_store_ignored", rd, 32'hDE22_BE44);
    @(posedge clk); #1;

    // Reset while a store to 0x20 sits in WAIT
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
    req_wdata = 32'h5555_AAAA; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstmid_in_wait", {30'd0, busy, req_ready}, 32'd2);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("rstmid_idle", {29'd0, req_ready, resp_valid, busy}, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid_still_idle", {30'd0, resp_valid, busy}, 32'd0);
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, ea);
    chk("rstmid_store_dropped", rd, 32'h0);
    chk("rstmid_err", {31'd0, er}, 32'd0);
    @(posedge clk); #1;

    // LATENCY=0 instance: one store then back-to-back loads, resp_ready tied high
    req_valid_b = 1'b1; req_write_b = 1'b1; req_addr_b = 32'h4;
    req_wdata_b = 32'h5A5A_1234; req_be_b = 4'hF;
    prev_rv = resp_valid_b;
    for (int k = 1; k <= 13; k++) begin
      rdy = req_ready_b;
      @(posedge clk); #1;
      if (rdy) begin
        acc_e.push_back(k);
        req_write_b = 1'b0;
      end
      if (resp_valid_b && !prev_rv) begin
        rise_e.push_back(k);
        chk($sformatf("l0_resp%0d_rdata", rise_e.size()), resp_rdata_b,
            (rise_e.size() == 1) ? 32'h0 : 32'h5A5A_1234);
        chk($sformatf("l0_resp%0d_err", rise_e.size()), {31'd0, resp_err_b}, 32'd0);
      end
      prev_rv = resp_valid_b;
    end
    req_valid_b = 1'b0;
    chk("l0_accept_count", 32'(acc_e.size()), 32'd5);
    chk("l0_resp_count", 32'(rise_e.size()), 32'd4);
    for (int i = 1; i < acc_e.size(); i++)
      chk($sformatf("l0_accept_spacing%0d", i), 32'(acc_e[i] - acc_e[i-1]), 32'd3);
    for (int i = 0; i < rise_e.size() && i < acc_e.size(); i++)
      chk($sformatf("l0_resp_delay%0d", i), 32'(rise_e[i] - acc_e[i]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
